// File: rtl/ov7670_capture_win.sv
// OV7670 capture engine: assembles byte pairs into pixels, crops/decimates a fixed window,
// optionally converts to grayscale and writes the frame linearly into a frame buffer.
module ov7670_capture_win #(
    parameter int DATA_WIDTH  = 8,
    parameter int IMG_WIDTH   = 320,
    parameter int IMG_HEIGHT  = 240,
    parameter int CROP_WIDTH  = 176,
    parameter int CROP_HEIGHT = 240,
    parameter int X_OFFSET    = 72,
    parameter int Y_OFFSET    = 0,
    parameter int DECIM       = 1,
    parameter int OUT_PIXELS  = (CROP_WIDTH / DECIM) * (CROP_HEIGHT / DECIM),
    parameter int ADDR_WIDTH  = $clog2(OUT_PIXELS)
) (
    input  logic                  pclk,
    input  logic                  reset,
    input  logic                  href,
    input  logic                  vsync,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  gray_mode,
    input  logic                  continuous,
    input  logic                  arm,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] wAddr,
    output logic [15:0]           wData,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  frame_err
);

    localparam int COL_W = $clog2(IMG_WIDTH + 1);
    localparam int ROW_W = $clog2(IMG_HEIGHT + 1);
    localparam int CNT_W = $clog2(OUT_PIXELS + 1);

    localparam logic [COL_W-1:0] X_LO   = COL_W'(X_OFFSET);
    localparam logic [COL_W-1:0] X_HI   = COL_W'(X_OFFSET + CROP_WIDTH);
    localparam logic [COL_W-1:0] COL_MX = COL_W'(IMG_WIDTH);
    localparam logic [COL_W-1:0] XMASK  = COL_W'(DECIM - 1);
    localparam logic [ROW_W-1:0] Y_LO   = ROW_W'(Y_OFFSET);
    localparam logic [ROW_W-1:0] Y_HI   = ROW_W'(Y_OFFSET + CROP_HEIGHT);
    localparam logic [ROW_W-1:0] ROW_MX = ROW_W'(IMG_HEIGHT);
    localparam logic [ROW_W-1:0] YMASK  = ROW_W'(DECIM - 1);
    localparam logic [CNT_W-1:0] OUT_C  = CNT_W'(OUT_PIXELS);

    typedef enum logic [1:0] {IDLE, WAIT_FRAME, CAPTURE} state_t;

    state_t                state;
    logic                  vsync_d, href_d;
    logic                  phase;
    logic [DATA_WIDTH-1:0] hi;
    logic [COL_W-1:0]      col;
    logic [ROW_W-1:0]      row;
    logic [CNT_W-1:0]      cnt;
    logic                  gray_lat;

    logic                  vld_p1;
    logic [ADDR_WIDTH-1:0] waddr_p1;
    logic [15:0]           wdata_p1;
    logic                  busy_p1, done_p1, err_p1;

    // Luma approximation: channels widened to 8 bits by replicating their MSBs, weights sum to 256.
    function automatic logic [7:0] rgb565_to_gray(input logic [15:0] p);
        logic [15:0] r8, g8, b8, acc;
        r8  = {8'd0, p[15:11], p[15:13]};
        g8  = {8'd0, p[10:5],  p[10:9]};
        b8  = {8'd0, p[4:0],   p[4:2]};
        acc = 16'd77 * r8 + 16'd150 * g8 + 16'd29 * b8;
        return acc[15:8];
    endfunction

    logic             frame_start, frame_end;
    logic [15:0]      pix_p0;
    logic [COL_W-1:0] col_rel;
    logic [ROW_W-1:0] row_rel;
    logic             keep_p0;

    // Stage p0: pixel assembly and window decision on the second byte
    always_comb begin
        frame_start = vsync_d & ~vsync;
        frame_end   = ~vsync_d & vsync;
        pix_p0      = 16'({hi, data});
        col_rel     = col - X_LO;
        row_rel     = row - Y_LO;
        keep_p0     = (col >= X_LO) && (col < X_HI) &&
                      (row >= Y_LO) && (row < Y_HI) &&
                      ((col_rel & XMASK) == '0) && ((row_rel & YMASK) == '0) &&
                      (cnt < OUT_C);
    end

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            vsync_d  <= 1'b0;
            href_d   <= 1'b0;
            phase    <= 1'b0;
            hi       <= '0;
            col      <= '0;
            row      <= '0;
            cnt      <= '0;
            gray_lat <= 1'b0;
            vld_p1   <= 1'b0;
            waddr_p1 <= '0;
            wdata_p1 <= '0;
            busy_p1  <= 1'b0;
            done_p1  <= 1'b0;
            err_p1   <= 1'b0;
        end else begin
            vsync_d <= vsync;
            href_d  <= href;
            vld_p1  <= 1'b0;
            done_p1 <= 1'b0;
            err_p1  <= 1'b0;

            case (state)
                IDLE: begin
                    if (arm || continuous) begin
                        state   <= WAIT_FRAME;
                        busy_p1 <= 1'b1;
                    end
                end
                WAIT_FRAME: begin
                    if (frame_start)
                        state <= CAPTURE;
                end
                CAPTURE: begin
                    if (frame_end) begin
                        done_p1 <= 1'b1;
                        err_p1  <= (cnt < OUT_C);
                        if (continuous) begin
                            state <= WAIT_FRAME;
                        end else begin
                            state   <= IDLE;
                            busy_p1 <= 1'b0;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    busy_p1 <= 1'b0;
                end
            endcase

            // Stage p1: counters advance, kept pixels are registered onto the write port
            if (frame_start) begin
                col      <= '0;
                row      <= '0;
                phase    <= 1'b0;
                cnt      <= '0;
                gray_lat <= gray_mode;
            end else begin
                if (href) begin
                    phase <= ~phase;
                    if (!phase) begin
                        hi <= data;
                    end else begin
                        if (col != COL_MX)
                            col <= col + 1'b1;
                        if (keep_p0 && state == CAPTURE) begin
                            vld_p1   <= 1'b1;
                            waddr_p1 <= cnt[ADDR_WIDTH-1:0];
                            wdata_p1 <= gray_lat ? {8'h00, rgb565_to_gray(pix_p0)} : pix_p0;
                            cnt      <= cnt + 1'b1;
                        end
                    end
                end else begin
                    col   <= '0;
                    phase <= 1'b0;
                end
                if (state == CAPTURE && href_d && !href && row != ROW_MX)
                    row <= row + 1'b1;
            end
        end
    end

    assign we         = vld_p1;
    assign wAddr      = waddr_p1;
    assign wData      = wdata_p1;
    assign busy       = busy_p1;
    assign frame_done = done_p1;
    assign frame_err  = err_p1;

endmodule

// File: tb/tb_ov7670_capture_win.sv
// Directed bench for ov7670_capture_win on a small 16x8 sensor with an 8x6 window at (4,1),
// decimation 2 (12 output pixels per frame).
module tb_ov7670_capture_win;

    localparam int IMG_W = 16;
    localparam int IMG_H = 8;
    localparam int CW    = 8;
    localparam int CH    = 6;
    localparam int XO    = 4;
    localparam int YO    = 1;
    localparam int DEC   = 2;
    localparam int OUTP  = 12;
    localparam int AW    = 4;

    logic          pclk = 1'b0;
    logic          reset;
    logic          href;
    logic          vsync;
    logic [7:0]    data;
    logic          gray_mode;
    logic          continuous;
    logic          arm;
    logic          we;
    logic [AW-1:0] wAddr;
    logic [15:0]   wData;
    logic          busy;
    logic          frame_done;
    logic          frame_err;

    ov7670_capture_win #(
        .DATA_WIDTH(8), .IMG_WIDTH(IMG_W), .IMG_HEIGHT(IMG_H),
        .CROP_WIDTH(CW), .CROP_HEIGHT(CH), .X_OFFSET(XO), .Y_OFFSET(YO), .DECIM(DEC)
    ) dut (
        .pclk(pclk), .reset(reset), .href(href), .vsync(vsync), .data(data),
        .gray_mode(gray_mode), .continuous(continuous), .arm(arm),
        .we(we), .wAddr(wAddr), .wData(wData), .busy(busy),
        .frame_done(frame_done), .frame_err(frame_err)
    );

    always #5 pclk = ~pclk;

    // write/status monitor, sampled on the falling edge
    logic [15:0] wq[$];
    int          aq[$];
    int          n_done = 0;
    int          n_err_with_done = 0;
    int          n_err_alone = 0;
    int          n_over = 0;

    always @(negedge pclk) begin
        if (we) begin
            wq.push_back(wData);
            aq.push_back(int'(wAddr));
            if (int'(wAddr) >= OUTP) n_over++;
        end
        if (frame_done) begin
            n_done++;
            if (frame_err) n_err_with_done++;
        end else if (frame_err) begin
            n_err_alone++;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] wq_at(input int i);
        if (i >= 0 && i < wq.size()) return wq[i];
        return 16'hxxxx;
    endfunction

    function automatic int aq_at(input int i);
        if (i >= 0 && i < aq.size()) return aq[i];
        return -1;
    endfunction

    task automatic drive_bytes(input int l, input int b0, input int b1, input bit coord,
                               input logic [7:0] hb, input logic [7:0] lb);
        for (int b = b0; b < b1; b++) begin
            href = 1'b1;
            if (b % 2 == 0) data = coord ? 8'(l) : hb;
            else            data = coord ? 8'(b / 2) : lb;
            @(negedge pclk);
        end
    endtask

    task automatic line_gap();
        href = 1'b0;
        data = 8'h00;
        repeat (4) @(negedge pclk);
    endtask

    task automatic frame_begin(input bit arm_now);
        @(negedge pclk);
        vsync = 1'b0;
        if (arm_now) arm = 1'b1;
        @(negedge pclk);
        arm = 1'b0;
        repeat (2) @(negedge pclk);
    endtask

    task automatic frame_end(input string tag, input logic exp_done, input logic exp_err);
        vsync = 1'b1;
        @(negedge pclk);
        check({tag, "_done"}, 32'(frame_done), 32'(exp_done));
        check({tag, "_err"}, 32'(frame_err), 32'(exp_err));
        @(negedge pclk);
        check({tag, "_done_1cyc"}, 32'(frame_done), 32'd0);
        repeat (4) @(negedge pclk);
    endtask

    task automatic send_frame(input string tag, input int nlines, input bit coord,
                              input logic [7:0] hb, input logic [7:0] lb, input bit arm_now,
                              input logic exp_done, input logic exp_err);
        frame_begin(arm_now);
        for (int l = 0; l < nlines; l++) begin
            drive_bytes(l, 0, 2 * IMG_W, coord, hb, lb);
            line_gap();
        end
        frame_end(tag, exp_done, exp_err);
    endtask

    // expected word for the i-th kept pixel of a coordinate frame: {row, col}
    function automatic logic [15:0] coord_exp(input int i);
        int r, c;
        r = YO + DEC * (i / (CW / DEC));
        c = XO + DEC * (i % (CW / DEC));
        return {8'(r), 8'(c)};
    endfunction

    typedef struct {
        logic [7:0]  hb;
        logic [7:0]  lb;
        logic        gm;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, d0;

        tbl[0] = '{8'h12, 8'h34, 1'b0, 16'h1234};
        tbl[1] = '{8'hFF, 8'hFF, 1'b0, 16'hFFFF};
        tbl[2] = '{8'hFF, 8'hFF, 1'b1, 16'h00FF};
        tbl[3] = '{8'h00, 8'h00, 1'b1, 16'h0000};
        tbl[4] = '{8'hF8, 8'h00, 1'b1, 16'h004C};
        tbl[5] = '{8'h07, 8'hE0, 1'b1, 16'h0095};
        tbl[6] = '{8'h00, 8'h1F, 1'b1, 16'h001C};
        tbl[7] = '{8'h84, 8'h10, 1'b1, 16'h0082};

        reset = 1'b1; href = 1'b0; vsync = 1'b1; data = 8'h00;
        gray_mode = 1'b0; continuous = 1'b0; arm = 1'b0;
        repeat (3) @(negedge pclk);
        check("rst_we", 32'(we), 32'd0);
        check("rst_waddr", 32'(wAddr), 32'd0);
        check("rst_wdata", 32'(wData), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_err", 32'(frame_err), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge pclk);
        check("idle_busy", 32'(busy), 32'd0);

        // continuous RGB capture of a coordinate-tagged frame
        continuous = 1'b1;
        @(negedge pclk);
        check("cont_busy", 32'(busy), 32'd1);
        base = wq.size(); d0 = n_done;
        send_frame("coord", IMG_H, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        check("coord_count", 32'(wq.size() - base), 32'(OUTP));
        for (int i = 0; i < OUTP; i++) begin
            check($sformatf("coord_data%0d", i), 32'(wq_at(base + i)), 32'(coord_exp(i)));
            check($sformatf("coord_addr%0d", i), 32'(aq_at(base + i)), 32'(i));
        end
        check("coord_ndone", 32'(n_done - d0), 32'd1);
        check("coord_busy_after", 32'(busy), 32'd1);

        // constant-pixel frames: RGB passthrough and grayscale conversion
        for (int v = 0; v < 8; v++) begin
            gray_mode = tbl[v].gm;
            base = wq.size();
            send_frame($sformatf("vec%0d", v), IMG_H, 1'b0, tbl[v].hb, tbl[v].lb, 1'b0, 1'b1, 1'b0);
            check($sformatf("vec%0d_count", v), 32'(wq.size() - base), 32'(OUTP));
            check($sformatf("vec%0d_first", v), 32'(wq_at(base)), 32'(tbl[v].exp));
            check($sformatf("vec%0d_last", v), 32'(wq_at(wq.size() - 1)), 32'(tbl[v].exp));
            check($sformatf("vec%0d_lastaddr", v), 32'(aq_at(aq.size() - 1)), 32'(OUTP - 1));
        end
        gray_mode = 1'b0;

        // short frame: only 3 lines, row 1 is the only kept row
        base = wq.size();
        send_frame("short", 3, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
        check("short_count", 32'(wq.size() - base), 32'd4);
        check("short_lastaddr", 32'(aq_at(aq.size() - 1)), 32'd3);
        check("short_lastdata", 32'(wq_at(wq.size() - 1)), 32'h010A);

        // continuous dropped: this frame completes, then IDLE
        continuous = 1'b0;
        base = wq.size();
        send_frame("lastcont", IMG_H, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        check("lastcont_count", 32'(wq.size() - base), 32'(OUTP));
        check("lastcont_busy", 32'(busy), 32'd0);

        // arm in the same cycle as frame start: that frame is skipped
        base = wq.size(); d0 = n_done;
        send_frame("armsync", IMG_H, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        check("armsync_count", 32'(wq.size() - base), 32'd0);
        check("armsync_busy", 32'(busy), 32'd1);
        send_frame("armnext", IMG_H, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        check("armnext_count", 32'(wq.size() - base), 32'(OUTP));
        check("armnext_first", 32'(aq_at(base)), 32'd0);
        check("armnext_busy", 32'(busy), 32'd0);

        // single shot over three frames
        @(negedge pclk); arm = 1'b1;
        @(negedge pclk); arm = 1'b0;
        check("ss_busy_armed", 32'(busy), 32'd1);
        base = wq.size(); d0 = n_done;
        send_frame("ss1", IMG_H, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        send_frame("ss2", IMG_H, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        send_frame("ss3", IMG_H, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        check("ss_count", 32'(wq.size() - base), 32'(OUTP));
        check("ss_ndone", 32'(n_done - d0), 32'd1);
        check("ss_busy_after", 32'(busy), 32'd0);

        // reset mid-line in a captured frame, released mid-frame
        continuous = 1'b1;
        @(negedge pclk);
        base = wq.size(); d0 = n_done;
        frame_begin(1'b0);
        for (int l = 0; l < 3; l++) begin
            drive_bytes(l, 0, 2 * IMG_W, 1'b1, 8'h00, 8'h00);
            line_gap();
        end
        drive_bytes(3, 0, 11, 1'b1, 8'h00, 8'h00);
        check("prerst_count", 32'(wq.size() - base), 32'd5);
        reset = 1'b1;
        drive_bytes(3, 11, 13, 1'b1, 8'h00, 8'h00);
        check("midrst_we", 32'(we), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_waddr", 32'(wAddr), 32'd0);
        reset = 1'b0;
        base = wq.size();
        drive_bytes(3, 13, 2 * IMG_W, 1'b1, 8'h00, 8'h00);
        line_gap();
        for (int l = 4; l < IMG_H; l++) begin
            drive_bytes(l, 0, 2 * IMG_W, 1'b1, 8'h00, 8'h00);
            line_gap();
        end
        frame_end("rstframe", 1'b0, 1'b0);
        check("postrst_count", 32'(wq.size() - base), 32'd0);
        check("postrst_ndone", 32'(n_done - d0), 32'd0);
        send_frame("rstnext", IMG_H, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        check("rstnext_count", 32'(wq.size() - base), 32'(OUTP));
        check("rstnext_first_addr", 32'(aq_at(base)), 32'd0);
        check("rstnext_first_data", 32'(wq_at(base)), 32'(coord_exp(0)));

        check("addr_overflow", 32'(n_over), 32'd0);
        check("err_without_done", 32'(n_err_alone), 32'd0);
        check("err_with_done", 32'(n_err_with_done), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ov7670_capture_win.md
# ov7670_capture_win

Parametrised OV7670 pixel-capture engine: the successor to the fixed-crop capture stage that sits behind the SCCB init block. It runs entirely in the camera `pclk` domain and assembles byte pairs into pixels. It applies a runtime-free, parameter-set crop window with X/Y offsets and integer decimation, and can emit either RGB565 or 8-bit grayscale. It writes the result linearly into the frame buffer, with single-shot/continuous arming and frame-done/error status.

## Interface
- DATA_WIDTH, 8: camera data bus width (bytes per pixel fixed at 2)
- IMG_WIDTH, 320: sensor pixels per line
- IMG_HEIGHT, 240: sensor lines per frame
- CROP_WIDTH, 176: crop window width in sensor pixels
- CROP_HEIGHT, 240: crop window height in sensor lines
- X_OFFSET, 72: first cropped column (X_OFFSET+CROP_WIDTH ≤ IMG_WIDTH)
- Y_OFFSET, 0: first cropped line (Y_OFFSET+CROP_HEIGHT ≤ IMG_HEIGHT)
- DECIM, 1: keep every DECIM-th column and line (1, 2 or 4; must divide CROP_WIDTH and CROP_HEIGHT)
- OUT_PIXELS, (CROP_WIDTH/DECIM)*(CROP_HEIGHT/DECIM): pixels per captured frame
- ADDR_WIDTH, $clog2(OUT_PIXELS): frame-buffer address width
- pclk  input  1  camera pixel clock; all logic on rising edge
- reset  input  1  asynchronous, active-high
- href  input  1  line valid
- vsync  input  1  frame sync, high during vertical blanking
- data  input  DATA_WIDTH  camera byte
- gray_mode  input  1  0 = RGB565 out, 1 = grayscale; sampled at frame start
- continuous  input  1  level; 1 = capture every frame
- arm  input  1  one-cycle pulse; request one frame
- we  output  1  frame-buffer write strobe
- wAddr  output  ADDR_WIDTH  write address
- wData  output  16  pixel word
- busy  output  1  state ≠ IDLE
- frame_done  output  1  one-cycle pulse at end of captured frame
- frame_err  output  1  one-cycle pulse with frame_done when pixel count ≠ OUT_PIXELS

## Operation
- Registers vsync_d and href_d (reset 0) for edge detection: frame start = vsync_d & ~vsync; frame end = ~vsync_d & vsync.
- FSM:
  - IDLE → WAIT_FRAME on arm or continuous.
  - WAIT_FRAME → CAPTURE on frame start.
  - CAPTURE → on frame end: pulse frame_done, then WAIT_FRAME if continuous else IDLE.
  - arm while busy is ignored.
- At frame start: row, col, byte phase and address counters clear; gray_mode latched.
- Byte phase toggles on every href=1 sample. Phase 0 stores the high byte; phase 1 completes a pixel {hi, data}.
- col increments per completed pixel and saturates at IMG_WIDTH. col and phase clear whenever href=0, so a partial pixel at a line end is discarded.
- row increments on href falling edge (href_d & ~href) in CAPTURE and saturates at IMG_HEIGHT.
- A pixel is kept iff all of:
  - X_OFFSET ≤ col < X_OFFSET+CROP_WIDTH
  - Y_OFFSET ≤ row < Y_OFFSET+CROP_HEIGHT
  - (col−X_OFFSET) mod DECIM = 0
  - (row−Y_OFFSET) mod DECIM = 0
  - address count < OUT_PIXELS
- Kept pixel → we=1, wAddr = current count, count+1. Count saturates at OUT_PIXELS; no wrap and no overwrite.
- RGB565 output: wData = {hi, lo}.
- Grayscale output: R=p[15:11], G=p[10:5], B=p[4:0].
  - gray = (77·{R,R[4:2]} + 150·{G,G[5:4]} + 29·{B,B[4:2]}) >> 8
  - 16-bit unsigned accumulate, so max 255·256 fits.
  - wData = {8'h00, gray}.
- frame_err pulses with frame_done if the final count < OUT_PIXELS (short frame).
- reset mid-frame: immediately IDLE with all counters 0. The next capture starts only at a subsequent frame start; no partial-frame writes.

## Timing
- Reset values: we=0, wAddr=0, wData=0, busy=0, frame_done=0, frame_err=0, FSM=IDLE.
- Outputs are registered. The second byte is sampled at edge N; we/wAddr/wData are valid after edge N and held for exactly one cycle (we=1 for one cycle per pixel).
- Max write rate: one write per 2 pclk.
- frame_done/frame_err are asserted the cycle after the edge where vsync is seen rising (vsync_d=0, vsync=1).
- busy deasserts in that same cycle when continuous=0.
- A frame start and an arm in the same cycle while IDLE: the FSM enters WAIT_FRAME, so that frame is missed and capture begins at the next frame start.
- A continuous deassert during CAPTURE finishes the current frame, then the FSM goes to IDLE.
- With href=1 during vsync=1 (blanking), nothing is written: writes occur only in CAPTURE.

## Test plan
- Defaults, continuous=1, full 320×240 RGB565 frame with data = col[7:0] per byte → 42240 writes, first wAddr=0 with wData=16'h4848 (col 72), last wAddr=42239, frame_done=1 with frame_err=0.
- DECIM=2, X_OFFSET=0, CROP 320×240 → 19200 writes, one pixel per 4 pclk on even lines only, odd lines produce no we.
- gray_mode=1 with pixels 16'hFFFF, 16'h0000 and 16'hF800 → wData 16'h00FF, 16'h0000 and 16'h004C.
- Single-shot: arm once, send 3 frames → only frame 1 written, frame_done pulses once, busy=0 afterward.
- Short frame: vsync rises after 100 lines → frame_done and frame_err pulse together, and wAddr never exceeds 17599.
- Reset asserted mid-line, then released mid-frame → no we until the next vsync falling edge, after which wAddr restarts at 0.
